// File: rtl/bch_pkg.sv
// Shared GF(2^M) arithmetic, default code parameters and FSM state type for the
// BCH syndrome unit. Field helpers operate on GF_MAX_W-bit containers (M < GF_MAX_W).
package bch_pkg;

  localparam int         DEF_M         = 4;
  localparam int         DEF_N         = 15;
  localparam int         DEF_T         = 2;
  localparam logic [4:0] DEF_PRIM_POLY = 5'b10011;
  localparam int         GF_MAX_W      = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SQUARE,
    DONE
  } bch_state_t;

  // Shift-and-add multiply, reducing after every shift so r stays below 2^m.
  function automatic logic [GF_MAX_W-1:0] gf_mul(input logic [GF_MAX_W-1:0] a,
                                                 input logic [GF_MAX_W-1:0] b,
                                                 input logic [GF_MAX_W:0]   poly,
                                                 input int                  m);
    logic [GF_MAX_W:0] r;
    r = '0;
    for (int i = GF_MAX_W - 1; i >= 0; i--) begin
      if (i < m) begin
        r = r << 1;
        if (r[m]) r = r ^ poly;
        if (b[i]) r = r ^ {1'b0, a};
      end
    end
    return r[GF_MAX_W-1:0];
  endfunction

  function automatic logic [GF_MAX_W-1:0] gf_alpha_pow(input int                j,
                                                       input logic [GF_MAX_W:0] poly,
                                                       input int                m);
    logic [GF_MAX_W-1:0] r;
    int                  e;
    e = j % ((1 << m) - 1);
    r = GF_MAX_W'(1);
    for (int i = 0; i < e; i++) r = gf_mul(r, GF_MAX_W'(2), poly, m);
    return r;
  endfunction

endpackage

// File: rtl/bch_gf_mul.sv
// Combinational GF(2^M) multiplier; thin wrapper around bch_pkg::gf_mul so the
// syndrome datapath can instantiate one per constant or squaring product.
module bch_gf_mul
  import bch_pkg::*;
#(
  parameter int         M         = DEF_M,
  parameter logic [M:0] PRIM_POLY = DEF_PRIM_POLY
) (
  input  logic [M-1:0] a_i,
  input  logic [M-1:0] b_i,
  output logic [M-1:0] p_o
);

  localparam logic [GF_MAX_W:0] POLY_EXT = (GF_MAX_W + 1)'(PRIM_POLY);

  logic [GF_MAX_W-1:0]   aExt;
  logic [GF_MAX_W-1:0]   bExt;
  logic [GF_MAX_W-1:0]   prod;
  logic [GF_MAX_W-M-1:0] unusedHi;

  always_comb begin
    aExt          = '0;
    bExt          = '0;
    aExt[M-1:0]   = a_i;
    bExt[M-1:0]   = b_i;
    prod          = gf_mul(aExt, bExt, POLY_EXT, M);
  end

  // Reduction guarantees the upper bits are zero; only the field element is used.
  assign {unusedHi, p_o} = prod;

endmodule

// File: rtl/bch_syndrome_unit.sv
// Bit-serial BCH syndrome calculator (Horner evaluation of r(alpha^j), j=1..2T).
// Define BCH_SYND_SQUARE_EN to keep only odd accumulators and derive even ones by squaring.
module bch_syndrome_unit
  import bch_pkg::*;
#(
  parameter int         M         = DEF_M,
  parameter int         N         = DEF_N,
  parameter int         T         = DEF_T,
  parameter logic [M:0] PRIM_POLY = DEF_PRIM_POLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             bit_data,
  output logic             bit_ready,
  output logic             synd_valid,
  input  logic             synd_ready,
  output logic [2*T*M-1:0] synd_data,
  output logic             synd_zero,
  output logic             busy
);

  localparam int                NS       = 2 * T;
  localparam int                CNT_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N - 1);
  localparam logic [GF_MAX_W:0] POLY_EXT = (GF_MAX_W + 1)'(PRIM_POLY);

  bch_state_t       state_q;
  logic [CNT_W-1:0] bitCnt_q;
  logic [M-1:0]     acc_q   [NS];
  logic [M-1:0]     acc_d   [NS];
  logic [M-1:0]     final_v [NS];
  logic             bit_ready_q;
  logic             synd_valid_q;
  logic             synd_zero_q;
  logic             busy_q;
  logic             accept;
  logic             finalZero;

  assign accept = (state_q == ACCUM) && bit_valid && bit_ready_q;

  for (genvar k = 0; k < NS; k++) begin : gHorner
    localparam logic [GF_MAX_W-1:0] ALPHA_FULL = gf_alpha_pow(k + 1, POLY_EXT, M);
    logic [M-1:0] prod;
`ifdef BCH_SYND_SQUARE_EN
    if (k % 2 == 0) begin : gMul
      bch_gf_mul #(.M(M), .PRIM_POLY(PRIM_POLY)) uMul (
        .a_i(acc_q[k]), .b_i(ALPHA_FULL[M-1:0]), .p_o(prod));
      assign acc_d[k] = prod ^ M'(bit_data);
    end else begin : gHold
      assign prod     = '0;
      assign acc_d[k] = acc_q[k];
    end
`else
    bch_gf_mul #(.M(M), .PRIM_POLY(PRIM_POLY)) uMul (
      .a_i(acc_q[k]), .b_i(ALPHA_FULL[M-1:0]), .p_o(prod));
    assign acc_d[k] = prod ^ M'(bit_data);
`endif
    assign synd_data[k*M +: M] = acc_q[k];
  end

`ifdef BCH_SYND_SQUARE_EN
  logic [M-1:0] sqFinal [T];

  // S_2i = S_i^2; even S_i comes from the lower squaring stage in the same cycle.
  for (genvar i = 1; i <= T; i++) begin : gSquare
    logic [M-1:0] base;
    logic [M-1:0] sq;
    if (i % 2 == 1) begin : gOdd
      assign base = acc_q[i-1];
    end else begin : gEven
      assign base = gSquare[i/2].sq;
    end
    bch_gf_mul #(.M(M), .PRIM_POLY(PRIM_POLY)) uSq (.a_i(base), .b_i(base), .p_o(sq));
    assign sqFinal[i-1] = sq;
  end
`endif

  always_comb begin
    finalZero = 1'b1;
    for (int k = 0; k < NS; k++) begin
`ifdef BCH_SYND_SQUARE_EN
      final_v[k] = (k % 2 == 0) ? acc_q[k] : sqFinal[k/2];
`else
      final_v[k] = acc_d[k];
`endif
      if (final_v[k] != '0) finalZero = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bitCnt_q     <= '0;
      bit_ready_q  <= 1'b0;
      synd_valid_q <= 1'b0;
      synd_zero_q  <= 1'b0;
      busy_q       <= 1'b0;
      for (int k = 0; k < NS; k++) acc_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < NS; k++) acc_q[k] <= '0;
            bitCnt_q    <= '0;
            state_q     <= ACCUM;
            bit_ready_q <= 1'b1;
            busy_q      <= 1'b1;
            synd_zero_q <= 1'b0;
          end
        end
        ACCUM: begin
          if (accept) begin
            for (int k = 0; k < NS; k++) acc_q[k] <= acc_d[k];
            bitCnt_q <= bitCnt_q + CNT_W'(1);
            if (bitCnt_q == LAST_CNT) begin
              bit_ready_q <= 1'b0;
`ifdef BCH_SYND_SQUARE_EN
              state_q <= SQUARE;
`else
              state_q      <= DONE;
              synd_valid_q <= 1'b1;
              synd_zero_q  <= finalZero;
`endif
            end
          end
        end
`ifdef BCH_SYND_SQUARE_EN
        SQUARE: begin
          for (int i = 0; i < T; i++) acc_q[2*i+1] <= sqFinal[i];
          state_q      <= DONE;
          synd_valid_q <= 1'b1;
          synd_zero_q  <= finalZero;
        end
`endif
        DONE: begin
          if (synd_ready) begin
            state_q      <= IDLE;
            synd_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bit_ready  = bit_ready_q;
  assign synd_valid = synd_valid_q;
  assign synd_zero  = synd_zero_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_bch_syndrome_unit.sv
// Scoreboard bench for bch_syndrome_unit (M=4, N=15, T=2); honours BCH_SYND_SQUARE_EN
// for the expected last-bit-to-valid latency.
module tb_bch_syndrome_unit;

  localparam int M = 4;
  localparam int N = 15;
  localparam int T = 2;
`ifdef BCH_SYND_SQUARE_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 1;
`endif

  typedef struct packed {
    logic [15:0] data;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_data = 1'b0;
  logic        synd_ready = 1'b1;
  logic        bit_ready;
  logic        synd_valid;
  logic [15:0] synd_data;
  logic        synd_zero;
  logic        busy;

  exp_t        expQ [$];
  exp_t        popped;
  int          errors = 0;
  int          checks = 0;
  logic [3:0]  alphaPow [15];

  bch_syndrome_unit #(.M(M), .N(N), .T(T), .PRIM_POLY(5'b10011)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .bit_data(bit_data),
    .bit_ready(bit_ready), .synd_valid(synd_valid), .synd_ready(synd_ready),
    .synd_data(synd_data), .synd_zero(synd_zero), .busy(busy));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Direct sum of alpha^(i*j) over set bits, independent of the Horner recurrence.
  function automatic logic [15:0] modelSynd(input logic [14:0] w);
    logic [15:0] r;
    r = '0;
    for (int j = 1; j <= 4; j++)
      for (int i = 0; i < 15; i++)
        if (w[i]) r[(j-1)*4 +: 4] = r[(j-1)*4 +: 4] ^ alphaPow[(i*j) % 15];
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && synd_valid && synd_ready) begin
      checkOutput("sb_pending", 32'(expQ.size() > 0), 32'd1);
      if (expQ.size() > 0) begin
        popped = expQ.pop_front();
        checkOutput("synd_data", 32'(synd_data), 32'(popped.data));
        checkOutput("synd_zero", 32'(synd_zero), 32'(popped.zero));
      end
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_bit_ready"}, 32'(bit_ready), 32'd0);
    checkOutput({tag, "_synd_valid"}, 32'(synd_valid), 32'd0);
    checkOutput({tag, "_synd_data"}, 32'(synd_data), 32'd0);
    checkOutput({tag, "_synd_zero"}, 32'(synd_zero), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic applyStimulus(input logic [14:0] word, input bit gaps,
                               input logic [15:0] expData, input int holdCycles);
    int lat;
    int cnt;
    expQ.push_back({expData, expData == 16'h0000});
    synd_ready = (holdCycles == 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_accum", 32'(busy), 32'd1);
    checkOutput("ready_accum", 32'(bit_ready), 32'd1);
    for (int i = N - 1; i >= 0; i--) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bit_valid = 1'b0;
          bit_data  = 1'($urandom);
          @(posedge clk); #1;
        end
      end
      bit_valid = 1'b1;
      bit_data  = word[i];
      @(posedge clk); #1;
    end
    bit_valid = 1'b0;
    checkOutput("ready_drop", 32'(bit_ready), 32'd0);
    lat = 1;
    while (!synd_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(EXP_LAT));
    if (holdCycles > 0) begin
      for (int c = 0; c < holdCycles; c++) begin
        start = (c == 2);
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("bp_data", 32'(synd_data), 32'(expData));
        checkOutput("bp_valid", 32'(synd_valid), 32'd1);
        checkOutput("bp_ready", 32'(bit_ready), 32'd0);
      end
      synd_ready = 1'b1;
      start      = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    cnt = 0;
    while (busy && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    checkOutput("return_idle", 32'(busy), 32'd0);
    checkOutput("idle_valid", 32'(synd_valid), 32'd0);
    checkOutput("hold_data", 32'(synd_data), 32'(expData));
  endtask

  initial begin
    logic [3:0]  p;
    logic [14:0] w;
    p = 4'b0001;
    for (int e = 0; e < 15; e++) begin
      alphaPow[e] = p;
      p = {p[2:0], 1'b0} ^ (p[3] ? 4'b0011 : 4'b0000);
    end

    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(15'h0000, 1'b0, 16'h0000, 0);
    applyStimulus(15'h0001, 1'b0, 16'h1111, 0);
    applyStimulus(15'h0002, 1'b0, 16'h3842, 0);
    applyStimulus(15'h4000, 1'b0, 16'hEFD9, 0);
    applyStimulus(15'h01D1, 1'b1, 16'h0000, 0);
    applyStimulus(15'h0002, 1'b0, 16'h3842, 5);

    // Abort a frame after 7 bits with an asynchronous reset.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bit_valid = 1'b1;
      bit_data  = 1'($urandom);
      @(posedge clk); #1;
    end
    bit_valid = 1'b0;
    #2 rst = 1'b1;
    #1 checkResetState("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    checkResetState("postrst");

    w = 15'h5A3C;
    applyStimulus(w, 1'b0, modelSynd(w), 0);
    for (int f = 0; f < 3; f++) begin
      w = 15'($urandom);
      applyStimulus(w, 1'b1, modelSynd(w), 0);
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb_drained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
